imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default DATA_WIDTH, meaning the immediate output width (legal values 32 or 64).
REQ-002 SHALL have parameter ILEN, default 32, meaning the instruction width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, asynchronous and active-high.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_inst (input, ILEN), forming the instruction-accept handshake.
REQ-006 SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the result handshake.
REQ-007 SHALL have ports out_imm (output, XLEN), out_fmt (output, 3, type imm_fmt_t) and out_illegal (output, 1).

Function
REQ-008 SHALL accept an input on a cycle where in_valid and in_ready are both high, and present the result on a cycle where out_valid and out_ready are both high.
REQ-009 SHALL have a latency of one cycle: an input accepted in cycle N is visible on the outputs in cycle N+1 with out_valid high.
REQ-010 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-011 SHALL hold out_imm, out_fmt and out_illegal stable while out_valid is high and out_ready is low.
REQ-012 SHALL implement a two-entry skid buffer with states EMPTY, ONE and TWO:
- EMPTY -> ONE on accept.
- ONE -> TWO on accept without output fire.
- ONE -> EMPTY on output fire without accept.
- ONE stays ONE on simultaneous accept and fire.
- TWO -> ONE on output fire.
REQ-013 SHALL drive in_ready directly from a register, high in EMPTY and ONE and low in TWO; in_ready SHALL have no combinational path from out_ready.
REQ-014 SHALL decode the immediate by opcode inst[6:0]:
- I (0010011, 0000011, 1100111): inst[31:20].
- S (0100011): {inst[31:25], inst[11:7]}.
- B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U (0110111, 0010111): {inst[31:12], 12'b0}.
- J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
REQ-015 SHALL sign-extend every I, S, B, U and J immediate from inst[31] to XLEN bits; for XLEN=64, U-type bits 63:32 SHALL equal inst[31].
REQ-016 SHALL output out_fmt = NONE, out_imm = 0 and out_illegal = 0 for the R-type (0110011), FENCE (0001111) and SYSTEM (1110011) opcodes, except as given in REQ-022.
REQ-017 SHALL output out_illegal = 1, out_fmt = NONE and out_imm = 0 for any other opcode, or whenever inst[1:0] != 2'b11.
REQ-018 SHALL treat an illegal instruction as an ordinary transfer, with no stall and no sticky state.

Reset
REQ-019 SHALL, while rst is high, force the state to EMPTY, out_valid to 0, in_ready to 1, out_imm to 0, out_fmt to NONE and out_illegal to 0.
REQ-020 SHALL discard both buffered entries when reset is asserted mid-operation, with no output fire afterwards for entries accepted before reset.
REQ-021 SHALL raise in_ready in the first clock edge after rst is released.

Configuration
REQ-022 SHALL, when the macro IMM_GEN_ZICSR_EN is defined, decode SYSTEM with funct3[2]=1 as format Z, with out_imm equal to inst[19:15] zero-extended to XLEN and out_illegal = 0.
REQ-023 SHALL, when IMM_GEN_ZICSR_EN is undefined, have no Z decode logic, so SYSTEM always follows REQ-016.

Structure
REQ-024 SHALL take DATA_WIDTH, the opcode localparams and the enum imm_fmt_t from my_pkg, with encodings I=0, S=1, B=2, U=3, J=4, Z=5, NONE=7.
REQ-025 SHALL contain one combinational sub-module, imm_decode (inst -> imm, fmt, illegal), instantiated once in front of the skid buffer.

Verification
REQ-026 SHALL cover: XLEN=32, 0xFFF00093 (addi x1,x0,-1) -> out_imm 0xFFFFFFFF, fmt I, illegal 0, one cycle later.
REQ-027 SHALL cover: XLEN=64, 0x800000B7 (lui) -> out_imm 0xFFFFFFFF80000000, fmt U; and 0x0040006F (jal x0,4) -> out_imm 0x4, fmt J.
REQ-028 SHALL cover: out_ready held low with in_valid high for 3 cycles -> exactly 2 accepts, in_ready low in cycle 3; then out_ready high -> both results leave in order, with no loss or duplication.
REQ-029 SHALL cover: 0x00000013 streamed with out_ready=1 for 16 cycles -> 16 outputs, one per cycle.
REQ-030 SHALL cover: with the macro defined, 0x000FD073 (csrrwi x0,0,31) -> out_imm 0x1F, fmt Z; without it -> out_imm 0, fmt NONE, illegal 0.
REQ-031 SHALL cover: 0x00000000 -> illegal 1, fmt NONE, imm 0; and rst asserted while in state TWO -> out_valid 0 immediately, in_ready 1.

Source files
------------

// File: rtl/my_pkg.sv
// my_pkg: shared immediate-format enum, skid-buffer state enum, RV opcodes and default width
package my_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_Z    = 3'd5,
    FMT_NONE = 3'd7
  } imm_fmt_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_st_t;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RV immediate extraction (inst -> imm, fmt, illegal).
// Ports: inst (ILEN) in; imm (XLEN), fmt (imm_fmt_t), illegal out.
// IMM_GEN_ZICSR_EN: when defined, SYSTEM with funct3[2]=1 decodes as FMT_Z (uimm in inst[19:15]).
module imm_decode
  import my_pkg::*;
#(
  parameter int XLEN = DATA_WIDTH,
  parameter int ILEN = 32
) (
  input  logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);
  // Every format is first built as a 32-bit value whose bit 31 is the extension bit,
  // so one signed cast handles both XLEN=32 and XLEN=64 (Z keeps bit 31 clear).
  logic signed [31:0] raw;
  always_comb begin
    raw = '0;
    fmt = FMT_NONE;
    illegal = 1'b0;
    if (inst[1:0] != 2'b11) illegal = 1'b1;
    else case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt = FMT_I;
        raw = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        fmt = FMT_S;
        raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        raw = {inst[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt = FMT_J;
        raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_OP, OP_FENCE: ;
      OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        if (inst[14]) begin
          fmt = FMT_Z;
          raw = {27'b0, inst[19:15]};
        end
`endif
      end
      default: illegal = 1'b1;
    endcase
  end
  assign imm = XLEN'(raw);
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate decoder followed by a two-entry skid buffer (1-cycle latency).
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_inst accept side;
// out_valid/out_ready result side with out_imm, out_fmt, out_illegal.
// IMM_GEN_ZICSR_EN: enables the Z (CSR uimm) format in imm_decode.
module imm_gen_pipe
  import my_pkg::*;
#(
  parameter int XLEN = DATA_WIDTH,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_t        out_fmt,
  output logic            out_illegal
);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_t        fmt;
    logic            ill;
  } ent_t;
  localparam ent_t ENT_RST = '{imm: '0, fmt: FMT_NONE, ill: 1'b0};
  ent_t dec_d, head_q, skid_q;
  skid_st_t state_q;
  logic in_ready_q, out_valid_q;
  imm_decode #(.XLEN(XLEN), .ILEN(ILEN)) u_dec (
    .inst    (in_inst),
    .imm     (dec_d.imm),
    .fmt     (dec_d.fmt),
    .illegal (dec_d.ill)
  );
  wire acc  = in_valid & in_ready_q;
  wire fire = out_valid_q & out_ready;
  // head_q always drives the outputs; skid_q only holds the entry that arrived while stalled.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      head_q <= ENT_RST;
      skid_q <= ENT_RST;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) begin
          head_q <= dec_d;
          state_q <= ST_ONE;
          out_valid_q <= 1'b1;
        end
        ST_ONE: if (acc && !fire) begin
          skid_q <= dec_d;
          state_q <= ST_TWO;
          in_ready_q <= 1'b0;
        end else if (acc) head_q <= dec_d;
        else if (fire) begin
          state_q <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
        ST_TWO: if (fire) begin
          head_q <= skid_q;
          state_q <= ST_ONE;
          in_ready_q <= 1'b1;
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm = head_q.imm;
  assign out_fmt = head_q.fmt;
  assign out_illegal = head_q.ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe at XLEN=32 and XLEN=64 side by side
module tb_imm_gen_pipe;
  import my_pkg::*;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic rdy32, rdy64, vld32, vld64, ill32, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  imm_fmt_t fmt32, fmt64;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  imm_gen_pipe u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
  );
  imm_gen_pipe #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic [63:0] exp, input logic [2:0] fmt, input logic ill);
    chk({tag, "_vld32"}, 64'(vld32), 64'd1);
    chk({tag, "_vld64"}, 64'(vld64), 64'd1);
    chk({tag, "_imm32"}, 64'(imm32), 64'(exp[31:0]));
    chk({tag, "_imm64"}, imm64, exp);
    chk({tag, "_fmt32"}, 64'(fmt32), 64'(fmt));
    chk({tag, "_fmt64"}, 64'(fmt64), 64'(fmt));
    chk({tag, "_ill32"}, 64'(ill32), 64'(ill));
    chk({tag, "_ill64"}, 64'(ill64), 64'(ill));
  endtask
  task automatic send(input string tag, input logic [31:0] inst, input logic [63:0] exp,
                      input logic [2:0] fmt, input logic ill);
    in_valid = 1'b1;
    in_inst = inst;
    out_ready = 1'b1;
    chk({tag, "_rdy"}, 64'(rdy32 & rdy64), 64'd1);
    tick();
    in_valid = 1'b0;
    chk_out(tag, exp, fmt, ill);
    tick();
    chk({tag, "_drain"}, 64'(vld32 | vld64), 64'd0);
  endtask
  initial begin
    int acc, outs, stalls;
    logic [63:0] csr_imm;
    logic [2:0] csr_fmt;
    tick();
    chk("rst_vld", 64'(vld32 | vld64), 64'd0);
    chk("rst_rdy", 64'(rdy32 & rdy64), 64'd1);
    chk("rst_imm", imm64 | 64'(imm32), 64'd0);
    chk("rst_fmt", 64'(fmt32), 64'd7);
    chk("rst_ill", 64'(ill32 | ill64), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_rdy", 64'(rdy32 & rdy64), 64'd1);
    send("addi_m1", 32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 1'b0);
    send("lui",     32'h800000B7, 64'hFFFFFFFF_80000000, 3'd3, 1'b0);
    send("jal4",    32'h0040006F, 64'h4, 3'd4, 1'b0);
    send("sw_m4",   32'hFE20AE23, 64'hFFFFFFFF_FFFFFFFC, 3'd1, 1'b0);
    send("beq_p8",  32'h00000463, 64'h8, 3'd2, 1'b0);
    send("beq_m2",  32'hFE000FE3, 64'hFFFFFFFF_FFFFFFFE, 3'd2, 1'b0);
    send("add",     32'h002081B3, 64'h0, 3'd7, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
    csr_imm = 64'h1F;
    csr_fmt = 3'd5;
`else
    csr_imm = 64'h0;
    csr_fmt = 3'd7;
`endif
    send("csrrwi",  32'h000FD073, csr_imm, csr_fmt, 1'b0);
    send("zero",    32'h00000000, 64'h0, 3'd7, 1'b1);
    send("bad_op",  32'h0000007F, 64'h0, 3'd7, 1'b1);
    send("bad_lo",  32'hFFF00091, 64'h0, 3'd7, 1'b1);
    // Back-pressure: two accepts fill the buffer, third cycle stalls.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_inst = 32'h00100093;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      if (rdy32) begin
        acc++;
        tick();
        in_inst = 32'h00200093;
      end else tick();
      if (i == 0) chk("bp_hold_first", 64'(imm32), 64'd1);
    end
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_rdy_low", 64'(rdy32 | rdy64), 64'd0);
    chk("bp_hold_imm", 64'(imm32), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk_out("bp_out0", 64'd1, 3'd0, 1'b0);
    tick();
    chk("bp_rdy_back", 64'(rdy32 & rdy64), 64'd1);
    chk_out("bp_out1", 64'd2, 3'd0, 1'b0);
    tick();
    chk("bp_empty", 64'(vld32 | vld64), 64'd0);
    // Streaming: one transfer per cycle with out_ready held high.
    in_valid = 1'b1;
    in_inst = 32'h00000013;
    acc = 0;
    outs = 0;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      if (rdy32) acc++; else stalls++;
      if (vld32) outs++;
      tick();
    end
    chk("st_outs_during", 64'(outs), 64'd15);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (vld32) outs++;
      tick();
    end
    chk("st_accepts", 64'(acc), 64'd16);
    chk("st_stalls", 64'(stalls), 64'd0);
    chk("st_outs", 64'(outs), 64'd16);
    // Reset while holding two entries.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_inst = 32'h00100093;
    tick();
    tick();
    in_valid = 1'b0;
    chk("two_rdy", 64'(rdy32 | rdy64), 64'd0);
    chk("two_vld", 64'(vld32 & vld64), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_vld", 64'(vld32 | vld64), 64'd0);
    chk("arst_rdy", 64'(rdy32 & rdy64), 64'd1);
    chk("arst_imm", imm64 | 64'(imm32), 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    outs = 0;
    for (int i = 0; i < 4; i++) begin
      if (vld32 | vld64) outs++;
      tick();
    end
    chk("arst_no_outs", 64'(outs), 64'd0);
    chk("arst_rdy_after", 64'(rdy32 & rdy64), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
